hippo_mem_initiator: RTL

- Command-driven initiator for the single-port BRAM memory block; it drives the memory side of the port (address, write enable, write data) and consumes its read data.
- Runs one burst of LEN words per command, starting at a base address and incrementing.
- Write bursts take words from a valid/ready stream and write them to memory. Read bursts fetch words and return them on a valid/ready stream with backpressure.
- Sits between a core- or loader-side streaming engine and the memory.

---
 rtl/hippo_mem_initiator.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/hippo_mem_initiator.sv
// hippo_mem_initiator: command-driven burst initiator for a single-port BRAM.
// Write bursts sink a valid/ready stream into memory; read bursts prefetch
// into a 2-entry FIFO and return words on a valid/ready stream.
//
// Ports:
//   clk_i, rst_ni          clock, async active-low reset
//   cmd_*                  burst command (valid/ready, write, addr, len)
//   wvalid_i/wready_o/wdata_i   write-data stream
//   rvalid_o/rready_i/rdata_o   read-data stream
//   busy_o, done_o         status (done_o pulses once per burst)
//   mem_addr_o/mem_we_o/mem_wdata_o/mem_rdata_i   BRAM port (1-cycle read)
module hippo_mem_initiator #(
    parameter int DATA_WIDTH = 8,
    parameter int MEM_DEPTH  = 1024,
    parameter int LEN_WIDTH  = 16,
    localparam int AddrWidth = $clog2(MEM_DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_write_i,
    input  logic [AddrWidth-1:0]  cmd_addr_i,
    input  logic [LEN_WIDTH-1:0]  cmd_len_i,
    input  logic                  wvalid_i,
    output logic                  wready_o,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  rvalid_o,
    input  logic                  rready_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [AddrWidth-1:0]  mem_addr_o,
    output logic                  mem_we_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        READ   = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t                state_q;
    logic [AddrWidth-1:0]  addr_q;
    logic [AddrWidth-1:0]  addr_inc;
    logic [LEN_WIDTH-1:0]  rem_q;
    logic                  inflight_q;

    logic [DATA_WIDTH-1:0] fifo_q [2];
    logic                  wr_ptr_q;
    logic                  rd_ptr_q;
    logic [1:0]            cnt_q;

    logic                  rem_zero;
    logic                  beat;
    logic                  push;
    logic                  pop;
    logic                  issue;
    logic                  rd_drain;
    logic [2:0]            occ;

    // Wrap explicitly so non-power-of-two depths still stay in range.
    assign addr_inc = (addr_q == AddrWidth'(MEM_DEPTH - 1))
                    ? '0 : addr_q + 1'b1;

    assign rem_zero = (rem_q == '0);
    assign beat     = (state_q == WRITE) && wvalid_i;

    assign rvalid_o = (cnt_q != 2'd0);
    assign rdata_o  = fifo_q[rd_ptr_q];
    assign pop      = rvalid_o & rready_i;
    assign push     = inflight_q;

    // Slots committed after this cycle's pop: stored words plus the word
    // already on its way back from memory. Issue only if one stays free.
    assign occ   = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue = (state_q == READ) && !rem_zero && (occ < 3'd2);

    assign rd_drain = rem_zero && !inflight_q
                   && (cnt_q == {1'b0, pop});

    assign cmd_ready_o = (state_q == IDLE);
    assign busy_o      = (state_q != IDLE);
    assign done_o      = (state_q == FINISH);
    assign wready_o    = (state_q == WRITE);

    assign mem_addr_o  = addr_q;
    assign mem_we_o    = beat;
    assign mem_wdata_o = wready_o ? wdata_i : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= issue;
            unique case (state_q)
                IDLE: begin
                    if (cmd_valid_i) begin
                        addr_q <= cmd_addr_i;
                        rem_q  <= cmd_len_i;
                        if (cmd_len_i == '0) begin
                            state_q <= FINISH;
                        end else if (cmd_write_i) begin
                            state_q <= WRITE;
                        end else begin
                            state_q <= READ;
                        end
                    end
                end
                WRITE: begin
                    if (beat) begin
                        addr_q <= addr_inc;
                        rem_q  <= rem_q - 1'b1;
                        if (rem_q == LEN_WIDTH'(1)) begin
                            state_q <= FINISH;
                        end
                    end
                end
                READ: begin
                    if (issue) begin
                        addr_q <= addr_inc;
                        rem_q  <= rem_q - 1'b1;
                    end
                    if (rd_drain) begin
                        state_q <= FINISH;
                    end
                end
                FINISH: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Read FIFO: the word fetched last cycle lands here; a push and a pop
    // in the same cycle leave the count unchanged.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            cnt_q     <= 2'd0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= mem_rdata_i;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule
